// File: rtl/decode_stage_pkg.sv
// decode_pkg: shared opcodes, ALU operation encoding, control bundle and
// immediate-format selectors for the decode stage.
// Defining DECODE_MEXT_EN adds the M-extension ALU operations, which widens
// the alu_op_e encoding to 5 bits.
package decode_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

`ifdef DECODE_MEXT_EN
  localparam int ALU_OP_MIN_W = 5;
`else
  localparam int ALU_OP_MIN_W = 4;
`endif

  typedef enum logic [ALU_OP_MIN_W-1:0] {
    ALU_ADD   = 0,
    ALU_SUB   = 1,
    ALU_SLL   = 2,
    ALU_SLT   = 3,
    ALU_SLTU  = 4,
    ALU_XOR   = 5,
    ALU_SRL   = 6,
    ALU_SRA   = 7,
    ALU_OR    = 8,
    ALU_AND   = 9,
    ALU_PASSB = 10
`ifdef DECODE_MEXT_EN
    ,
    ALU_MUL    = 16,
    ALU_MULH   = 17,
    ALU_MULHSU = 18,
    ALU_MULHU  = 19,
    ALU_DIV    = 20,
    ALU_DIVU   = 21,
    ALU_REM    = 22,
    ALU_REMU   = 23
`endif
  } alu_op_e;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic alu_src;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
  } ctrl_t;

  // Base integer operation selected by funct3 (shared by R and I-ALU forms).
  function automatic alu_op_e r_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

`ifdef DECODE_MEXT_EN
  // Multiply/divide operation selected by funct3 when funct7 = 0000001.
  function automatic alu_op_e m_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return ALU_MUL;
      3'b001:  return ALU_MULH;
      3'b010:  return ALU_MULHSU;
      3'b011:  return ALU_MULHU;
      3'b100:  return ALU_DIV;
      3'b101:  return ALU_DIVU;
      3'b110:  return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction
`endif

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side handshake plus the decoded
// bundle. The slave modport is the decode stage itself; master is its
// environment (fetch + execute).
interface decode_stage_if #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
);

  logic                flush_i;
  logic                in_valid_i;
  logic                in_ready_o;
  logic [31:0]         instruction_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [4:0]          rd_o;
  logic [4:0]          rs1_o;
  logic [4:0]          rs2_o;
  logic [XLEN-1:0]     imm_o;
  logic [ALU_OP_W-1:0] alu_op_o;
  logic                alu_src_o;
  logic                reg_write_o;
  logic                mem_read_o;
  logic                mem_write_o;
  logic                branch_o;
  logic                jump_o;
  logic                illegal_o;

  modport slave (
    input  flush_i, in_valid_i, instruction_i, out_ready_i,
    output in_ready_o, out_valid_o, rd_o, rs1_o, rs2_o, imm_o, alu_op_o,
           alu_src_o, reg_write_o, mem_read_o, mem_write_o, branch_o,
           jump_o, illegal_o
  );

  modport master (
    output flush_i, in_valid_i, instruction_i, out_ready_i,
    input  in_ready_o, out_valid_o, rd_o, rs1_o, rs2_o, imm_o, alu_op_o,
           alu_src_o, reg_write_o, mem_read_o, mem_write_o, branch_o,
           jump_o, illegal_o
  );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational immediate assembly for the I, S, B, U and J
// formats, sign-extended from instr[31] to XLEN. FMT_NONE yields zero.
// Only instr[31:7] carries immediate bits, so the opcode field is not a port.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  // Scatter the instruction bits into a 32-bit immediate for the chosen format.
  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Bit 31 of every format is instr[31], so a signed widen extends correctly.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered instruction decode between fetch and execute.
// One-deep pipeline register with valid/ready on both sides, a flush that
// beats capture, and an illegal flag that still produces a valid bundle so
// execute can trap. Define DECODE_MEXT_EN to decode the M extension
// (requires ALU_OP_W >= 5).
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
) (
  input logic           clk_i,
  input logic           rst_n_i,
  decode_stage_if.slave bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("decode_stage: XLEN must be 32 or 64");
  end

  if (ALU_OP_W < ALU_OP_MIN_W) begin : g_bad_alu_op_w
    $error("decode_stage: ALU_OP_W too narrow for the alu_op_e encoding");
  end

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [5:0]  shift_hi;
  logic        shamt_bad;

  assign instr     = bus.instruction_i;
  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];
  // Shift-immediate upper bits above the shamt; on RV32 shamt[5] must be 0.
  assign shift_hi  = funct7[6:1];
  assign shamt_bad = (XLEN == 32) && funct7[0];

  alu_op_e         dec_op;
  ctrl_t           dec_ctrl;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_imm;

  // Opcode/funct decode into ALU op, control flags, immediate format and legality.
  always_comb begin
    dec_op      = ALU_ADD;
    dec_ctrl    = '0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;

    case (opcode)
      OPC_R: begin
        dec_ctrl.reg_write = 1'b1;
        if (funct7 == 7'b0000000) begin
          dec_op = r_op(funct3);
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_op = ALU_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          dec_op = ALU_SRA;
`ifdef DECODE_MEXT_EN
        end else if (funct7 == 7'b0000001) begin
          dec_op = m_op(funct3);
`endif
        end else begin
          dec_illegal = 1'b1;
        end
      end

      OPC_IALU: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_fmt            = FMT_I;
        dec_op             = r_op(funct3);
        if (funct3 == 3'b001) begin
          if (shift_hi != 6'b000000 || shamt_bad) dec_illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          dec_op = funct7[5] ? ALU_SRA : ALU_SRL;
          if ((shift_hi != 6'b000000 && shift_hi != 6'b010000) || shamt_bad)
            dec_illegal = 1'b1;
        end
      end

      OPC_LOAD: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.mem_read  = 1'b1;
        dec_fmt            = FMT_I;
        // LB, LH, LW, LBU, LHU only.
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
          dec_illegal = 1'b1;
      end

      OPC_STORE: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.mem_write = 1'b1;
        dec_fmt            = FMT_S;
        // SB, SH, SW only.
        if (funct3[2] || funct3 == 3'b011) dec_illegal = 1'b1;
      end

      OPC_BRANCH: begin
        dec_ctrl.branch = 1'b1;
        dec_op          = ALU_SUB;
        dec_fmt         = FMT_B;
        if (funct3 == 3'b010 || funct3 == 3'b011) dec_illegal = 1'b1;
      end

      OPC_LUI: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_op             = ALU_PASSB;
        dec_fmt            = FMT_U;
      end

      OPC_JAL: begin
        dec_ctrl.jump      = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_fmt            = FMT_J;
      end

      OPC_JALR: begin
        dec_ctrl.jump      = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_fmt            = FMT_I;
        if (funct3 != 3'b000) dec_illegal = 1'b1;
      end

      default: dec_illegal = 1'b1;
    endcase

    // An undecodable instruction carries no side effects and no immediate.
    if (dec_illegal) begin
      dec_ctrl = '0;
      dec_op   = ALU_ADD;
      dec_fmt  = FMT_NONE;
    end

    // Writes to x0 are dropped here so execute never has to special-case it.
    if (instr[11:7] == 5'd0) dec_ctrl.reg_write = 1'b0;
  end

  imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .instr (instr[31:7]),
    .fmt   (dec_fmt),
    .imm   (dec_imm)
  );

  logic            out_valid_q;
  logic [4:0]      rd_q;
  logic [4:0]      rs1_q;
  logic [4:0]      rs2_q;
  logic [XLEN-1:0] imm_q;
  alu_op_e         alu_op_q;
  ctrl_t           ctrl_q;
  logic            illegal_q;
  logic            in_ready;
  logic            accept;

  assign in_ready = !out_valid_q || bus.out_ready_i;
  assign accept   = bus.in_valid_i && in_ready;

  // Valid flag: flush beats capture; a consumed bundle with nothing new drains.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_q <= 1'b0;
    end else if (bus.flush_i) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
    end else if (out_valid_q && bus.out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  // Payload loads only on a non-flushed accept, so it holds through stalls.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      alu_op_q  <= ALU_ADD;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else if (accept && !bus.flush_i) begin
      rd_q      <= instr[11:7];
      rs1_q     <= instr[19:15];
      rs2_q     <= instr[24:20];
      imm_q     <= dec_imm;
      alu_op_q  <= dec_op;
      ctrl_q    <= dec_ctrl;
      illegal_q <= dec_illegal;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.rd_o        = rd_q;
  assign bus.rs1_o       = rs1_q;
  assign bus.rs2_o       = rs2_q;
  assign bus.imm_o       = imm_q;
  assign bus.alu_op_o    = ALU_OP_W'(alu_op_q);
  assign bus.alu_src_o   = ctrl_q.alu_src;
  assign bus.reg_write_o = ctrl_q.reg_write;
  assign bus.mem_read_o  = ctrl_q.mem_read;
  assign bus.mem_write_o = ctrl_q.mem_write;
  assign bus.branch_o    = ctrl_q.branch;
  assign bus.jump_o      = ctrl_q.jump;
  assign bus.illegal_o   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vector table, hand-written handshake/flush/reset
// sequences, and a randomized run against a behavioural decode model.
module tb_decode_stage;
  import decode_pkg::*;

  localparam int AW = ALU_OP_MIN_W;

  logic clk;
  logic rst_n;

  decode_stage_if #(.XLEN(32), .ALU_OP_W(AW)) bus ();

  decode_stage #(.XLEN(32), .ALU_OP_W(AW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observed bundle: {pad, illegal, alu_op, six flags, rd, rs1, rs2, imm}.
  logic [63:0] act;
  assign act = {5'b0, bus.illegal_o, 5'(bus.alu_op_o), bus.alu_src_o,
                bus.reg_write_o, bus.mem_read_o, bus.mem_write_o,
                bus.branch_o, bus.jump_o, bus.rd_o, bus.rs1_o, bus.rs2_o,
                bus.imm_o};

  task automatic chk1(input string name, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, a, e);
    end
  endtask

  task automatic chkw(input string name, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, a, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  localparam logic [4:0] R_OPS [8] = '{5'(ALU_ADD), 5'(ALU_SLL), 5'(ALU_SLT),
                                       5'(ALU_SLTU), 5'(ALU_XOR), 5'(ALU_SRL),
                                       5'(ALU_OR), 5'(ALU_AND)};
`ifdef DECODE_MEXT_EN
  localparam logic [4:0] M_OPS [8] = '{5'(ALU_MUL), 5'(ALU_MULH), 5'(ALU_MULHSU),
                                       5'(ALU_MULHU), 5'(ALU_DIV), 5'(ALU_DIVU),
                                       5'(ALU_REM), 5'(ALU_REMU)};
`endif

  // Reference decode: immediates by shifting/masking, legality by format rules.
  function automatic logic [63:0] model(input logic [31:0] ins);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] s20;
    logic [31:0] sgn;
    logic        ill;
    logic [4:0]  alu;
    logic [5:0]  fl;
    logic [31:0] imm;
    op  = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    s20 = 32'($signed(ins) >>> 20);
    sgn = 32'($signed(ins) >>> 31);
    ill = 1'b0;
    alu = 5'(ALU_ADD);
    fl  = 6'b000000;
    imm = 32'h0;
    case (op)
      7'b0110011: begin
        fl = 6'b010000;
        if (f7 == 7'h00) alu = R_OPS[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) alu = 5'(ALU_SUB);
        else if (f7 == 7'h20 && f3 == 3'd5) alu = 5'(ALU_SRA);
`ifdef DECODE_MEXT_EN
        else if (f7 == 7'h01) alu = M_OPS[f3];
`endif
        else ill = 1'b1;
      end
      7'b0010011: begin
        fl  = 6'b110000;
        imm = s20;
        alu = R_OPS[f3];
        if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
        if (f3 == 3'd5) begin
          if (f7 == 7'h20) alu = 5'(ALU_SRA);
          else if (f7 != 7'h00) ill = 1'b1;
        end
      end
      7'b0000011: begin
        fl  = 6'b111000;
        imm = s20;
        if (f3 == 3'd3 || f3 > 3'd5) ill = 1'b1;
      end
      7'b0100011: begin
        fl  = 6'b100100;
        imm = (s20 & ~32'h1f) | ((ins >> 7) & 32'h1f);
        if (f3 > 3'd2) ill = 1'b1;
      end
      7'b1100011: begin
        fl  = 6'b000010;
        alu = 5'(ALU_SUB);
        imm = (sgn << 12) | (((ins >> 7) & 32'h1) << 11) |
              (((ins >> 25) & 32'h3f) << 5) | (((ins >> 8) & 32'hf) << 1);
        if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
      end
      7'b0110111: begin
        fl  = 6'b110000;
        alu = 5'(ALU_PASSB);
        imm = ins & 32'hFFFFF000;
      end
      7'b1101111: begin
        fl  = 6'b010001;
        imm = (sgn << 20) | (ins & 32'h000FF000) | (((ins >> 20) & 32'h1) << 11) |
              (((ins >> 21) & 32'h3ff) << 1);
      end
      7'b1100111: begin
        fl  = 6'b110001;
        imm = s20;
        if (f3 != 3'd0) ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      alu = 5'(ALU_ADD);
      fl  = 6'b000000;
      imm = 32'h0;
    end
    if (ins[11:7] == 5'd0) fl[4] = 1'b0;
    return {5'b0, ill, alu, fl, ins[11:7], ins[19:15], ins[24:20], imm};
  endfunction

  localparam logic [6:0] OPCS [8] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                      7'b0100011, 7'b1100011, 7'b0110111,
                                      7'b1101111, 7'b1100111};
  localparam logic [6:0] F7S [3] = '{7'h00, 7'h20, 7'h01};

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 3) != 0) begin
      r[6:0] = OPCS[$urandom_range(0, 7)];
      if ($urandom_range(0, 1) == 1) r[31:25] = F7S[$urandom_range(0, 2)];
    end
    return r;
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic        illegal;
    logic [4:0]  op;
    logic [5:0]  ctrl;   // alu_src reg_write mem_read mem_write branch jump
    logic [31:0] imm;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] vec_pack(input vec_t v);
    return {5'b0, v.illegal, v.op, v.ctrl, v.instr[11:7], v.instr[19:15],
            v.instr[24:20], v.imm};
  endfunction

  localparam logic [31:0] I_ADDI = 32'hFFF08293;
  localparam logic [31:0] I_SW   = 32'h0021A423;
  localparam logic [31:0] I_BEQ  = 32'hFE208EE3;
  localparam logic [31:0] I_LW   = 32'h0043A303;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        exp_valid;
    logic [63:0] exp_word;
    logic [31:0] ins;
    logic        iv, ordy, fl;

    vecs.push_back('{I_ADDI,       1'b0, 5'(ALU_ADD),   6'b110000, 32'hFFFFFFFF});
    vecs.push_back('{I_SW,         1'b0, 5'(ALU_ADD),   6'b100100, 32'h00000008});
    vecs.push_back('{I_BEQ,        1'b0, 5'(ALU_SUB),   6'b000010, 32'hFFFFFFFC});
    vecs.push_back('{I_LW,         1'b0, 5'(ALU_ADD),   6'b111000, 32'h00000004});
    vecs.push_back('{32'h12345537, 1'b0, 5'(ALU_PASSB), 6'b110000, 32'h12345000});
    vecs.push_back('{32'h800000B7, 1'b0, 5'(ALU_PASSB), 6'b110000, 32'h80000000});
    vecs.push_back('{32'h008000EF, 1'b0, 5'(ALU_ADD),   6'b010001, 32'h00000008});
    vecs.push_back('{32'hFFFFF06F, 1'b0, 5'(ALU_ADD),   6'b000001, 32'hFFFFFFFE});
    vecs.push_back('{32'h000280E7, 1'b0, 5'(ALU_ADD),   6'b110001, 32'h00000000});
    vecs.push_back('{32'h00000000, 1'b1, 5'(ALU_ADD),   6'b000000, 32'h00000000});
    vecs.push_back('{32'h402081B3, 1'b0, 5'(ALU_SUB),   6'b010000, 32'h00000000});
    vecs.push_back('{32'h4030D213, 1'b0, 5'(ALU_SRA),   6'b110000, 32'h00000403});
    vecs.push_back('{32'h02009093, 1'b1, 5'(ALU_ADD),   6'b000000, 32'h00000000});
    vecs.push_back('{32'h00208033, 1'b0, 5'(ALU_ADD),   6'b000000, 32'h00000000});
    vecs.push_back('{32'h40209033, 1'b1, 5'(ALU_ADD),   6'b000000, 32'h00000000});
    vecs.push_back('{32'hFE20AEE3, 1'b1, 5'(ALU_ADD),   6'b000000, 32'h00000000});
`ifdef DECODE_MEXT_EN
    vecs.push_back('{32'h02208033, 1'b0, 5'(ALU_MUL),   6'b000000, 32'h00000000});
`else
    vecs.push_back('{32'h02208033, 1'b1, 5'(ALU_ADD),   6'b000000, 32'h00000000});
`endif

    // Reset held while fetch offers an instruction.
    rst_n             = 1'b0;
    bus.flush_i       = 1'b0;
    bus.in_valid_i    = 1'b1;
    bus.instruction_i = I_ADDI;
    bus.out_ready_i   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_out_valid", bus.out_valid_o, 1'b0);
    chkw("rst_bundle", act, 64'h0);
    rst_n          = 1'b1;
    bus.in_valid_i = 1'b0;
    #1;
    chk1("rst_in_ready", bus.in_ready_o, 1'b1);

    // Directed table, applied back to back with execute always ready.
    bus.out_ready_i = 1'b1;
    foreach (vecs[k]) begin
      bus.in_valid_i    = 1'b1;
      bus.instruction_i = vecs[k].instr;
      if (k == 0) begin
        #1;
        chk1("latency_pre_valid", bus.out_valid_o, 1'b0);
      end
      cyc();
      chk1($sformatf("vec%0d_valid", k), bus.out_valid_o, 1'b1);
      chkw($sformatf("vec%0d_bundle", k), act, vec_pack(vecs[k]));
    end

    // Backpressure: LW held for three cycles while ADDI waits.
    bus.instruction_i = I_LW;
    cyc();
    chkw("bp_lw", act, model(I_LW));
    bus.out_ready_i   = 1'b0;
    bus.instruction_i = I_ADDI;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk1("bp_in_ready", bus.in_ready_o, 1'b0);
      cyc();
      chk1("bp_valid", bus.out_valid_o, 1'b1);
      chkw("bp_hold", act, model(I_LW));
    end
    bus.out_ready_i = 1'b1;
    #1;
    chk1("bp_release_ready", bus.in_ready_o, 1'b1);
    cyc();
    chkw("bp_next", act, model(I_ADDI));

    // Flush while holding SW and offered BEQ.
    bus.instruction_i = I_SW;
    cyc();
    chk1("fl_pre_valid", bus.out_valid_o, 1'b1);
    bus.out_ready_i   = 1'b0;
    bus.flush_i       = 1'b1;
    bus.instruction_i = I_BEQ;
    cyc();
    chk1("fl_valid", bus.out_valid_o, 1'b0);
    bus.flush_i     = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    cyc();
    chk1("fl_stays_empty", bus.out_valid_o, 1'b0);

    // Asynchronous reset in the middle of a stall.
    bus.in_valid_i    = 1'b1;
    bus.instruction_i = I_LW;
    cyc();
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    cyc();
    chk1("stall_valid", bus.out_valid_o, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("async_rst_valid", bus.out_valid_o, 1'b0);
    chkw("async_rst_bundle", act, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Randomized traffic against the reference model.
    exp_valid = 1'b0;
    exp_word  = 64'h0;
    chk1("rnd_start_empty", bus.out_valid_o, 1'b0);
    for (int i = 0; i < 400; i++) begin
      ins  = rnd_instr();
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 15) == 0);
      bus.instruction_i = ins;
      bus.in_valid_i    = iv;
      bus.out_ready_i   = ordy;
      bus.flush_i       = fl;
      #1;
      chk1("rnd_in_ready", bus.in_ready_o, !exp_valid || ordy);
      @(posedge clk);
      if (fl) begin
        exp_valid = 1'b0;
      end else if (iv && (!exp_valid || ordy)) begin
        exp_valid = 1'b1;
        exp_word  = model(ins);
      end else if (exp_valid && ordy) begin
        exp_valid = 1'b0;
      end
      #1;
      chk1("rnd_valid", bus.out_valid_o, exp_valid);
      if (exp_valid) chkw($sformatf("rnd_bundle_%08h", ins), act, exp_word);
    end
    bus.flush_i    = 1'b0;
    bus.in_valid_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I instruction decode stage, parametrised successor of the purely combinational control unit.
- Sits between fetch and execute and decodes R, I-ALU, LOAD, STORE, BRANCH, LUI, JAL and JALR formats.
- Produces an XLEN-wide sign-extended immediate and a full control bundle.
- Uses a valid/ready handshake on both sides, a flush input, and an illegal-instruction flag.

Parameters:
- XLEN, 32, datapath width; the immediate is sign-extended to XLEN. Legal values are 32 and 64.
- ALU_OP_W, 4, width of the alu_op_o encoding.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- flush_i  in  1  squashes any held or arriving instruction.
- in_valid_i  in  1  fetch presents an instruction.
- in_ready_o  out  1  stage can accept an instruction this cycle.
- instruction_i  in  32  raw instruction.
- out_valid_o  out  1  decoded bundle is valid.
- out_ready_i  in  1  execute consumes the bundle.
- rd_o, rs1_o, rs2_o  out  5 each  register indices.
- imm_o  out  XLEN  sign-extended immediate.
- alu_op_o  out  ALU_OP_W  ALU operation (package enum).
- alu_src_o  out  1  1 selects the immediate, 0 selects rs2.
- reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o  out  1 each  control flags.
- illegal_o  out  1  the held instruction is not decodable.

Behaviour:
- Reset (asynchronous, rst_n_i=0): every output register clears to 0, including out_valid_o.
  - After reset, in_ready_o=1 combinationally.
- Handshake:
  - in_ready_o = !out_valid_o || out_ready_i.
  - An input transfer happens when in_valid_i && in_ready_o; the decoded bundle is registered and out_valid_o=1 on the next cycle. Latency is 1 cycle.
  - An output transfer happens when out_valid_o && out_ready_i.
  - If an output transfer occurs and there is no new input, out_valid_o falls to 0.
  - Simultaneous output and input transfers give back-to-back throughput of 1 per cycle.
  - While out_valid_o=1 && out_ready_i=0, all outputs hold stable.
- Flush: flush_i=1 forces out_valid_o to 0 at the next edge and discards any input offered that cycle. Flush has priority over capture.
- Decode by opcode [6:0]:
  - 0110011 (R): alu_src=0, reg_write=1; alu_op from funct3 and funct7[5].
  - 0010011 (I-ALU): alu_src=1, reg_write=1, imm=I.
    - For SRLI/SRAI, funct7[5] selects the operation.
    - For shifts with XLEN=32, instr[25]=1 is illegal.
  - 0000011 (LOAD): alu_src=1, reg_write=1, mem_read=1, alu_op=ADD, imm=I.
  - 0100011 (STORE): alu_src=1, mem_write=1, alu_op=ADD, imm=S.
  - 1100011 (BRANCH): alu_src=0, branch=1, alu_op=SUB, imm=B.
  - 0110111 (LUI): alu_src=1, reg_write=1, alu_op=PASSB, imm=U.
  - 1101111 (JAL): jump=1, reg_write=1, imm=J.
  - 1100111 (JALR): jump=1, reg_write=1, alu_src=1, imm=I.
- Immediates are sign-extended from instr[31] to XLEN. The B and J forms have bit 0 = 0.
- Illegal handling: any other opcode, or an invalid funct3/funct7 combination, sets illegal_o=1.
  - All write, memory, branch and jump flags are forced to 0.
  - out_valid_o still asserts, so execute sees and traps on it.
- Register fields: rd_o, rs1_o and rs2_o are always the raw fields [11:7], [19:15] and [24:20], regardless of format.
- rd=x0 with reg_write=1: reg_write_o is forced to 0.

Optional Feature:
- Macro DECODE_MEXT_EN.
- Defined: opcode 0110011 with funct7=0000001 decodes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU to dedicated alu_op values, with reg_write=1. ALU_OP_W must be at least 5; an elaboration-time check enforces this.
- Not defined: funct7=0000001 is illegal.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams;
  - the alu_op_e enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB, plus the M operations under the macro);
  - the ctrl_t packed struct bundling the control flags;
  - imm-format constants.
- One natural sub-module: imm_gen, a combinational block taking instr and format and returning an XLEN immediate.
- The pipeline register and handshake stay in decode_stage.

Test Plan:
- Reset with in_valid_i=1: all outputs 0, out_valid_o=0 during reset. After release, in_ready_o=1.
- ADDI x5,x1,-1 (0xFFF08293): one cycle later out_valid_o=1, rd=5, rs1=1, imm=0xFFFFFFFF, alu_src=1, reg_write=1, alu_op=ADD.
- Back-to-back stream:
  - SW x2,8(x3), then BEQ x1,x2,-4, with out_ready_i=1.
  - SW: one bundle per cycle, mem_write=1, imm=8.
  - BEQ: branch=1, imm=0xFFFFFFFC.
- Backpressure:
  - out_ready_i=0 for 3 cycles with LW pending: outputs stable, in_ready_o=0.
  - After release, the next instruction is captured in the same cycle.
- Flush:
  - flush_i=1 while out_valid_o=1 and a new instruction is offered: next cycle out_valid_o=0 and neither instruction appears.
  - Asynchronous reset asserted mid-stall also clears the stage immediately.
- Illegal and M-extension encodings:
  - 0x00000000: illegal_o=1, all flags 0.
  - 0x02208033 (MUL): alu_op=MUL under DECODE_MEXT_EN, otherwise illegal_o=1.
